// File: rtl/pipelined_barrel_shifter.sv
// Pipelined N-bit barrel shifter: five shift/rotate modes plus pass-through, STAGES register
// stages, valid/ready flow control on both sides and an opaque tag carried with each operation.
module pipelined_barrel_shifter #(
    parameter int N      = 16,
    parameter int C      = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [C-1:0]     in_cnt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("pipelined_barrel_shifter: N must be a power of two and at least 4");
    end
    if (C != $clog2(N)) begin : g_bad_c
        $error("pipelined_barrel_shifter: C must equal log2(N)");
    end
    if (STAGES < 1 || STAGES > C) begin : g_bad_stages
        $error("pipelined_barrel_shifter: STAGES must lie in 1..C");
    end

    // One level of the shifter: moves data by 2^lvl in the direction/fill the mode selects.
    function automatic logic [N-1:0] shift_level(input logic [N-1:0] d, input int lvl,
                                                 input logic [2:0] op, input logic fill);
        int amt;
        logic [N-1:0] r;
        amt = 1 << lvl;
        case (op)
            OP_ROL:  r = (d << amt) | (d >> (N - amt));
            OP_SLL:  r = d << amt;
            OP_ROR:  r = (d >> amt) | (d << (N - amt));
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = (d >> amt) | (fill ? ~({N{1'b1}} >> amt) : '0);
            default: r = d;
        endcase
        return r;
    endfunction

    logic [STAGES-1:0]  valid_q;
    logic [N-1:0]       data_q  [STAGES];
    logic [C-1:0]       cnt_q   [STAGES];
    logic [2:0]         op_q    [STAGES];
    logic [TAG_W-1:0]   tag_q   [STAGES];
    logic               fill_q  [STAGES];

    logic [STAGES-1:0]  st_valid;
    logic [N-1:0]       st_data [STAGES];
    logic [C-1:0]       st_cnt  [STAGES];
    logic [2:0]         st_op   [STAGES];
    logic [TAG_W-1:0]   st_tag  [STAGES];
    logic               st_fill [STAGES];
    logic [N-1:0]       shifted [STAGES];
    logic [STAGES-1:0]  ready;
    logic               stall;

    // Handshake: a stage loads when it is empty or its contents leave this cycle
    // (ready_k = !valid_k || ready_k+1, last stage sees out_ready). A transfer happens on
    // valid && ready at the rising edge; in_ready never depends on in_valid.
    always_comb begin
        stall = !out_ready;
        ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stall    = stall && valid_q[k];
            ready[k] = !stall;
        end
    end

    always_comb begin
        st_valid[0] = in_valid;
        st_data[0]  = in_data;
        st_cnt[0]   = in_cnt;
        st_op[0]    = in_op;
        st_tag[0]   = in_tag;
        st_fill[0]  = in_data[N-1];
        for (int k = 1; k < STAGES; k++) begin
            st_valid[k] = valid_q[k-1];
            st_data[k]  = data_q[k-1];
            st_cnt[k]   = cnt_q[k-1];
            st_op[k]    = op_q[k-1];
            st_tag[k]   = tag_q[k-1];
            st_fill[k]  = fill_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            shifted[k] = st_data[k];
            for (int i = 0; i < C; i++) begin
                if ((i * STAGES) / C == k && st_cnt[k][i]) begin
                    shifted[k] = shift_level(shifted[k], i, st_op[k], st_fill[k]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready[k]) begin
                    valid_q[k] <= st_valid[k];
                end
            end
        end
    end

    // Payload registers only load on a real transfer so a stalled result stays put.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (ready[k] && st_valid[k]) begin
                data_q[k] <= shifted[k];
                cnt_q[k]  <= st_cnt[k];
                op_q[k]   <= st_op[k];
                tag_q[k]  <= st_tag[k];
                fill_q[k] <= st_fill[k];
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter (N=16, STAGES=2): vector table, streaming,
// backpressure, simultaneous accept/deliver, mid-flight reset and a full mode/count sweep.
module tb_pipelined_barrel_shifter;

    localparam int N  = 16;
    localparam int C  = 4;
    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [C-1:0]  in_cnt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic          busy;

    pipelined_barrel_shifter #(.N(N), .C(C), .STAGES(S), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cnt(in_cnt),
        .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  cnt;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[6];

    int n_vec = 0;
    int n_err = 0;
    logic [TW+N-1:0] exp_q[$];
    int acc_q[$];
    bit check_lat = 1'b0;
    int n_del = 0;
    int del_first = -1;
    int del_last = -1;
    logic [TW+N-1:0] mon_e;
    int mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] c,
                                              input logic [2:0] o);
        logic [15:0] r;
        r = d;
        for (int j = 0; j < int'(c); j++) begin
            case (o)
                3'b000:  r = {r[14:0], r[15]};
                3'b001:  r = {r[14:0], 1'b0};
                3'b010:  r = {r[0], r[15:1]};
                3'b011:  r = {1'b0, r[15:1]};
                3'b100:  r = {r[15], r[15:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // scoreboard: every delivered result is checked against the head of the expected queue
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {12'd0, out_tag, out_data}, 32'hDEAD_BEEF);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = acc_q.pop_front();
                check("out_data", 32'(out_data), 32'(mon_e[N-1:0]));
                check("out_tag", 32'(out_tag), 32'(mon_e[TW+N-1:N]));
                if (check_lat) check("latency", 32'(cyc - mon_a), S);
                n_del++;
                if (del_first < 0) del_first = cyc;
                del_last = cyc;
            end
        end
    end

    // driver tasks
    task automatic send(input logic [15:0] d, input logic [3:0] c, input logic [2:0] o,
                        input logic [3:0] t, input logic [15:0] e, output int acc);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_cnt   = c;
        in_op    = o;
        in_tag   = t;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 1);
            acc = -1;
        end else begin
            exp_q.push_back({t, e});
            acc_q.push_back(cyc);
            acc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || busy) && w < 50) begin
            w++;
            @(negedge clk);
        end
        check("drain_queue", exp_q.size(), 0);
        check("drain_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int t0;
        int t_last;
        int n0;
        logic [15:0] d;
        logic [3:0] c;
        logic [2:0] o;
        logic [15:0] e;

        vecs[0] = '{16'h8001, 4'd1,  3'b000, 4'd1, 16'h0003};
        vecs[1] = '{16'h0001, 4'd1,  3'b010, 4'd2, 16'h8000};
        vecs[2] = '{16'hFFFF, 4'd8,  3'b001, 4'd3, 16'hFF00};
        vecs[3] = '{16'h8001, 4'd4,  3'b011, 4'd4, 16'h0800};
        vecs[4] = '{16'h8000, 4'd15, 3'b100, 4'd5, 16'hFFFF};
        vecs[5] = '{16'h1234, 4'd5,  3'b111, 4'd6, 16'h1234};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single operations from the vector table
        check_lat = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].cnt, vecs[i].op, vecs[i].tag, vecs[i].exp, acc);
            drain();
        end

        // streaming: 16 back-to-back operations
        del_first = -1;
        n0 = n_del;
        t0 = 0;
        t_last = 0;
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom_range(0, 16'hFFFF));
            c = 4'($urandom_range(0, 15));
            o = 3'($urandom_range(0, 7));
            send(d, c, o, 4'(i), ref_shift(d, c, o), acc);
            if (i == 0) t0 = acc;
            t_last = acc;
        end
        drain();
        check("stream_accept_span", 32'(t_last - t0), 15);
        check("stream_count", 32'(n_del - n0), 16);
        check("stream_deliver_span", 32'(del_last - del_first), 15);

        // backpressure: two accepted, third blocked while the head result holds
        check_lat = 1'b0;
        n0 = n_del;
        out_ready = 1'b0;
        send(16'h1111, 4'd1, 3'b001, 4'd1, 16'h2222, acc);
        send(16'h00F0, 4'd4, 3'b010, 4'd2, 16'h000F, acc);
        in_valid = 1'b1;
        in_data  = 16'h8000;
        in_cnt   = 4'd3;
        in_op    = 3'b100;
        in_tag   = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_hold_data", 32'(out_data), 32'h2222);
            check("bp_hold_tag", 32'(out_tag), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_resume_ready", 32'(in_ready), 1);
        exp_q.push_back({4'd3, 16'hF000});
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("bp_count", 32'(n_del - n0), 3);

        // simultaneous accept/deliver with a full pipe
        out_ready = 1'b0;
        send(16'h0001, 4'd3, 3'b000, 4'd7, 16'h0008, acc);
        send(16'h0100, 4'd2, 3'b011, 4'd8, 16'h0040, acc);
        out_ready = 1'b1;
        n0 = n_del;
        t0 = 0;
        t_last = 0;
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom_range(0, 16'hFFFF));
            c = 4'($urandom_range(0, 15));
            o = 3'($urandom_range(0, 4));
            send(d, c, o, 4'(9 + i), ref_shift(d, c, o), acc);
            if (i == 0) t0 = acc;
            t_last = acc;
            check("sim_busy", 32'(busy), 1);
        end
        check("sim_accept_span", 32'(t_last - t0), 3);
        check("sim_delivered", 32'(n_del - n0), 4);
        drain();
        check("sim_total", 32'(n_del - n0), 6);

        // reset with two operations in flight
        check_lat = 1'b1;
        send(16'h1357, 4'd2, 3'b000, 4'd1, 16'h4D5C, acc);
        send(16'h2468, 4'd1, 3'b001, 4'd2, 16'h48D0, acc);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n0 = n_del;
        send(16'h0F0F, 4'd4, 3'b000, 4'd9, 16'hF0F0, acc);
        drain();
        check("midrst_count", 32'(n_del - n0), 1);

        // sweep every count for the five shift modes on one operand
        n0 = n_del;
        for (int op = 0; op < 5; op++) begin
            for (int k = 0; k < 16; k++) begin
                e = (k == 0) ? 16'hA5C3 : ref_shift(16'hA5C3, 4'(k), 3'(op));
                send(16'hA5C3, 4'(k), 3'(op), 4'(k), e, acc);
            end
        end
        drain();
        check("sweep_count", 32'(n_del - n0), 80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
